// File: rtl/nearest_neighbor_engine_if.sv
`default_nettype none
// ============================================================================
// Module  : nearest_neighbor_engine_if
// Purpose : Control, source-read and destination-write bus of the NN scaler.
// Revision: 1.0
// ============================================================================
interface nearest_neighbor_engine_if #(
    parameter int PIX_W    = 8,
    parameter int R_ADDR_W = 15,
    parameter int W_ADDR_W = 19
);
    logic                START;
    logic                MODE;
    logic [1:0]          SHIFT_FACTOR;
    logic [R_ADDR_W-1:0] R_ADDR;
    logic                R_EN;
    logic [PIX_W-1:0]    R_DATA;
    logic [W_ADDR_W-1:0] W_ADDR;
    logic                W_EN;
    logic [PIX_W-1:0]    W_DATA;
    logic                BUSY;
    logic                DONE;

    modport master (
        output START, MODE, SHIFT_FACTOR, R_DATA,
        input  R_ADDR, R_EN, W_ADDR, W_EN, W_DATA, BUSY, DONE
    );

    modport slave (
        input  START, MODE, SHIFT_FACTOR, R_DATA,
        output R_ADDR, R_EN, W_ADDR, W_EN, W_DATA, BUSY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/nearest_neighbor_engine.sv
`default_nettype none
// ============================================================================
// Module  : nearest_neighbor_engine
// Purpose : Power-of-two nearest-neighbour image scaler; NN_ZOOM_OUT_EN adds
//           the decimating (MODE=1) path, otherwise the engine only zooms in.
// Revision: 1.0
// ============================================================================
module nearest_neighbor_engine #(
    parameter int IMG_W_IN  = 160,
    parameter int IMG_H_IN  = 120,
    parameter int PIX_W     = 8,
    parameter int R_ADDR_W  = 15,
    parameter int W_ADDR_W  = 19,
    parameter int MAX_SHIFT = 2
) (
    input  wire logic                   CLK,
    input  wire logic                   RST_N,
    nearest_neighbor_engine_if.slave    bus
);

    localparam int W_MAX = IMG_W_IN << MAX_SHIFT;
    localparam int H_MAX = IMG_H_IN << MAX_SHIFT;
    localparam int XW    = $clog2(W_MAX + 1);
    localparam int YW    = $clog2(H_MAX + 1);

    localparam logic [XW-1:0]       C_W_IN   = XW'(IMG_W_IN);
    localparam logic [YW-1:0]       C_H_IN   = YW'(IMG_H_IN);
    localparam logic [XW-1:0]       C_X_ONE  = XW'(1);
    localparam logic [YW-1:0]       C_Y_ONE  = YW'(1);
    localparam logic [W_ADDR_W-1:0] C_P_ONE  = W_ADDR_W'(1);
    localparam logic [R_ADDR_W-1:0] C_STRIDE = R_ADDR_W'(IMG_W_IN);
    localparam logic [1:0]          C_MAX_S  = 2'(MAX_SHIFT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q;
    logic [1:0]          s_q;
    logic [XW-1:0]       x_q;
    logic [YW-1:0]       y_q;
    logic [W_ADDR_W-1:0] pix_q;
    logic                r_en_q;
    logic [R_ADDR_W-1:0] r_addr_q;
    logic                v1_q;
    logic [W_ADDR_W-1:0] a1_q;
    logic                w_en_q;
    logic [W_ADDR_W-1:0] w_addr_q;
    logic [PIX_W-1:0]    w_data_q;
    logic                busy_q;
    logic                done_q;

    logic [1:0]          w_s_new;
    logic [XW-1:0]       w_w_out;
    logic [YW-1:0]       w_h_out;
    logic                w_x_last;
    logic                w_y_last;
    logic [XW-1:0]       w_x_nxt;
    logic [YW-1:0]       w_y_nxt;
    logic [R_ADDR_W-1:0] w_raddr_zi;
    logic [R_ADDR_W-1:0] w_raddr_nxt;

`ifdef NN_ZOOM_OUT_EN
    logic                mode_q;
    logic [R_ADDR_W-1:0] w_raddr_zo;
`else
    logic                w_unused_mode;
    assign w_unused_mode = bus.MODE;
`endif

    assign w_s_new = (bus.SHIFT_FACTOR > C_MAX_S) ? C_MAX_S : bus.SHIFT_FACTOR;

    always_comb begin
        w_w_out     = C_W_IN << s_q;
        w_h_out     = C_H_IN << s_q;
        w_x_last    = (x_q == (w_w_out - C_X_ONE));
        w_y_last    = (y_q == (w_h_out - C_Y_ONE));
        w_x_nxt     = w_x_last ? '0 : (x_q + C_X_ONE);
        w_y_nxt     = w_x_last ? (y_q + C_Y_ONE) : y_q;
        w_raddr_zi  = R_ADDR_W'(w_y_nxt >> s_q) * C_STRIDE + R_ADDR_W'(w_x_nxt >> s_q);
        w_raddr_nxt = w_raddr_zi;
`ifdef NN_ZOOM_OUT_EN
        // Decimation: output coordinates never exceed IN>>s, so <<s stays in range.
        w_raddr_zo  = R_ADDR_W'(w_y_nxt << s_q) * C_STRIDE + R_ADDR_W'(w_x_nxt << s_q);
        if (mode_q) begin
            w_w_out     = C_W_IN >> s_q;
            w_h_out     = C_H_IN >> s_q;
            w_x_last    = (x_q == (w_w_out - C_X_ONE));
            w_y_last    = (y_q == (w_h_out - C_Y_ONE));
            w_x_nxt     = w_x_last ? '0 : (x_q + C_X_ONE);
            w_y_nxt     = w_x_last ? (y_q + C_Y_ONE) : y_q;
            w_raddr_zo  = R_ADDR_W'(w_y_nxt << s_q) * C_STRIDE + R_ADDR_W'(w_x_nxt << s_q);
            w_raddr_nxt = w_raddr_zo;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            s_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            pix_q    <= '0;
            r_en_q   <= 1'b0;
            r_addr_q <= '0;
            v1_q     <= 1'b0;
            a1_q     <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NN_ZOOM_OUT_EN
            mode_q   <= 1'b0;
`endif
        end else begin
            // Write pipeline: read strobe -> data-return stage -> registered write.
            v1_q   <= r_en_q;
            a1_q   <= pix_q;
            w_en_q <= v1_q;
            if (v1_q) begin
                w_addr_q <= a1_q;
                w_data_q <= bus.R_DATA;
            end

            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.START) begin
                        state_q  <= RUN;
                        s_q      <= w_s_new;
`ifdef NN_ZOOM_OUT_EN
                        mode_q   <= bus.MODE;
`endif
                        x_q      <= '0;
                        y_q      <= '0;
                        pix_q    <= '0;
                        r_en_q   <= 1'b1;
                        r_addr_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_x_last && w_y_last) begin
                        state_q <= FLUSH;
                        r_en_q  <= 1'b0;
                    end else begin
                        x_q      <= w_x_nxt;
                        y_q      <= w_y_nxt;
                        pix_q    <= pix_q + C_P_ONE;
                        r_addr_q <= w_raddr_nxt;
                    end
                end
                FLUSH: begin
                    // Last write is on the bus once the return stage has drained.
                    if (!v1_q) begin
                        state_q <= FINISH;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.R_EN   = r_en_q;
    assign bus.R_ADDR = r_addr_q;
    assign bus.W_EN   = w_en_q;
    assign bus.W_ADDR = w_addr_q;
    assign bus.W_DATA = w_data_q;
    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nearest_neighbor_engine.sv
`default_nettype none
// ============================================================================
// Module  : tb_nearest_neighbor_engine
// Purpose : Cycle-accurate self-checking bench on a reduced 12x8 source image.
// Revision: 1.0
// ============================================================================
module tb_nearest_neighbor_engine;

    localparam int IW  = 12;
    localparam int IH  = 8;
    localparam int PW  = 8;
    localparam int RAW = 8;
    localparam int WAW = 11;
    localparam int MS  = 2;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    nearest_neighbor_engine_if #(.PIX_W(PW), .R_ADDR_W(RAW), .W_ADDR_W(WAW)) bus ();

    nearest_neighbor_engine #(
        .IMG_W_IN(IW), .IMG_H_IN(IH), .PIX_W(PW),
        .R_ADDR_W(RAW), .W_ADDR_W(WAW), .MAX_SHIFT(MS)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus.slave)
    );

    logic [PW-1:0] mem [256];
    always @(posedge CLK) if (bus.R_EN) bus.R_DATA <= mem[bus.R_ADDR];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int eff_s(input int shift);
        return (shift > MS) ? MS : shift;
    endfunction

    function automatic bit zoom_out(input bit mode);
`ifdef NN_ZOOM_OUT_EN
        return mode;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int out_w(input bit mode, input int shift);
        return zoom_out(mode) ? (IW >> eff_s(shift)) : (IW << eff_s(shift));
    endfunction

    function automatic int out_h(input bit mode, input int shift);
        return zoom_out(mode) ? (IH >> eff_s(shift)) : (IH << eff_s(shift));
    endfunction

    // Source pixel feeding output raster index k.
    function automatic int src_addr(input int k, input bit mode, input int shift);
        int s, x, y;
        s = eff_s(shift);
        x = k % out_w(mode, shift);
        y = k / out_w(mode, shift);
        if (zoom_out(mode)) return (y * (1 << s)) * IW + x * (1 << s);
        return (y / (1 << s)) * IW + x / (1 << s);
    endfunction

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = PW'($urandom);
    endtask

    task automatic run_frame(input bit mode, input int shift, input int restart_at, input int reset_at);
        int n, writes, dones, s;
        bit zo;
        n      = out_w(mode, shift) * out_h(mode, shift);
        s      = eff_s(shift);
        zo     = zoom_out(mode);
        writes = 0;
        dones  = 0;
        @(negedge CLK);
        bus.START        = 1'b1;
        bus.MODE         = mode;
        bus.SHIFT_FACTOR = shift[1:0];
        @(negedge CLK);
        bus.START = 1'b0;
        for (int c = 0; c < n + 4; c++) begin
            check("r_en", bus.R_EN, c < n);
            if (c < n) check("r_addr", bus.R_ADDR, src_addr(c, mode, shift));
            check("w_en", bus.W_EN, (c >= 2) && (c < n + 2));
            if (c >= 2 && c < n + 2) begin
                check("w_addr", bus.W_ADDR, c - 2);
                check("w_data", bus.W_DATA, mem[src_addr(c - 2, mode, shift)]);
            end
            check("busy", bus.BUSY, c < n + 2);
            check("done", bus.DONE, c == n + 2);
            if (!zo && s == 1 && c == 1)  check("spot_out10_raddr", bus.R_ADDR, 0);
            if (!zo && s == 1 && c == 50) check("spot_out22_raddr", bus.R_ADDR, 13);
            if (zo && s == 2 && c == 4)   check("spot_zo_out11_raddr", bus.R_ADDR, 52);
            writes += int'(bus.W_EN);
            dones  += int'(bus.DONE);
            if (c == reset_at) begin
                RST_N = 1'b0;
                @(negedge CLK);
                RST_N = 1'b1;
                check("abort_r_en", bus.R_EN, 0);
                check("abort_w_en", bus.W_EN, 0);
                check("abort_busy", bus.BUSY, 0);
                check("abort_done", bus.DONE, 0);
                dones = 0;
                for (int k = 0; k < 6; k++) begin
                    @(negedge CLK);
                    dones += int'(bus.DONE) + int'(bus.R_EN) + int'(bus.W_EN) + int'(bus.BUSY);
                end
                check("abort_quiet", dones, 0);
                return;
            end
            if (c == restart_at) begin
                bus.START        = 1'b1;
                bus.MODE         = ~mode;
                bus.SHIFT_FACTOR = shift[1:0] ^ 2'b01;
            end else begin
                bus.START = 1'b0;
            end
            @(negedge CLK);
        end
        check("write_count", writes, n);
        check("done_count", dones, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.START        = 1'b0;
        bus.MODE         = 1'b0;
        bus.SHIFT_FACTOR = 2'd0;
        randomize_mem();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_r_en",   bus.R_EN,   0);
        check("rst_w_en",   bus.W_EN,   0);
        check("rst_busy",   bus.BUSY,   0);
        check("rst_done",   bus.DONE,   0);
        check("rst_r_addr", bus.R_ADDR, 0);
        check("rst_w_addr", bus.W_ADDR, 0);
        check("rst_w_data", bus.W_DATA, 0);
        RST_N = 1'b1;
        @(negedge CLK);

        run_frame(1'b0, 1, -1, -1);
        run_frame(1'b1, 2, -1, -1);
        run_frame(1'b0, 3, -1, -1);
        run_frame(1'b0, 1, 10, -1);
        run_frame(1'b0, 1, -1, 200);
        randomize_mem();
        run_frame(1'b0, 1, -1, -1);
        run_frame(1'b1, 1, -1, -1);
        for (int i = 0; i < 4; i++) begin
            randomize_mem();
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nearest_neighbor_engine.md
NEAREST_NEIGHBOR_ENGINE -- requirements
Module: nearest_neighbor_engine

Interface
REQ-001 Parameter IMG_W_IN, default 160: source image width in pixels.
REQ-002 Parameter IMG_H_IN, default 120: source image height in pixels.
REQ-003 Parameter PIX_W, default 8: pixel width in bits.
REQ-004 Parameter R_ADDR_W, default 15: source address width.
REQ-005 Parameter W_ADDR_W, default 19: destination address width.
REQ-006 Parameter MAX_SHIFT, default 2: largest scale exponent supported.
REQ-007 CLK  input  1  single clock; all logic on rising edge.
REQ-008 RST_N  input  1  synchronous, active-low reset.
REQ-009 START  input  1  one-cycle request to begin a frame.
REQ-010 MODE  input  1  0 = zoom-in (replicate), 1 = zoom-out (decimate).
REQ-011 SHIFT_FACTOR  input  2  scale exponent; factor = 2^SHIFT_FACTOR.
REQ-012 R_ADDR  output  R_ADDR_W  source read address.
REQ-013 R_EN  output  1  source read strobe.
REQ-014 R_DATA  input  PIX_W  source pixel, valid the cycle after R_EN.
REQ-015 W_ADDR  output  W_ADDR_W  destination write address.
REQ-016 W_EN  output  1  destination write strobe.
REQ-017 W_DATA  output  PIX_W  destination pixel.
REQ-018 BUSY  output  1  high while a frame is in progress.
REQ-019 DONE  output  1  one-cycle pulse at frame completion.

Function
REQ-020 The engine SHALL use FSM states IDLE, RUN, FLUSH, FINISH; IDLE->RUN on START, RUN->FLUSH after last read issued, FLUSH->FINISH after last write, FINISH->IDLE after one cycle.
REQ-021 MODE and SHIFT_FACTOR SHALL be latched on the START cycle and held constant for the frame; s = min(SHIFT_FACTOR, MAX_SHIFT).
REQ-022 Output dimensions SHALL be W_OUT = IMG_W_IN<<s, H_OUT = IMG_H_IN<<s in zoom-in and IMG_W_IN>>s, IMG_H_IN>>s (floor) in zoom-out.
REQ-023 In RUN the engine SHALL walk output (x,y) raster order, x fastest, one pixel per cycle, asserting R_EN every RUN cycle.
REQ-024 R_ADDR SHALL be (y>>s)*IMG_W_IN + (x>>s) in zoom-in and (y<<s)*IMG_W_IN + (x<<s) in zoom-out.
REQ-025 W_EN, W_ADDR = y*W_OUT + x and W_DATA = R_DATA (registered) SHALL appear exactly 2 cycles after the matching R_EN.
REQ-026 First R_EN SHALL occur the cycle after START is sampled; frame of N pixels issues N consecutive R_EN, then N consecutive W_EN.
REQ-027 BUSY SHALL rise the cycle after START and fall in the FINISH cycle, in which DONE pulses high.
REQ-028 START asserted while BUSY SHALL be ignored with no effect on the running frame.
REQ-029 Outside RUN no R_EN, outside the write pipeline no W_EN; address counters SHALL not wrap past W_OUT*H_OUT-1.

Reset
REQ-030 On RST_N low at a clock edge: state IDLE, counters 0, R_EN=0, W_EN=0, BUSY=0, DONE=0, R_ADDR=0, W_ADDR=0, W_DATA=0.
REQ-031 Reset mid-frame SHALL abort immediately; no further R_EN/W_EN, no DONE for the aborted frame.

Configuration
REQ-032 Macro NN_ZOOM_OUT_EN: defined -> MODE=1 selects decimation per REQ-022/024; undefined -> decimation logic absent, MODE ignored, engine always zoom-in.

Verification
REQ-033 MODE=0, SHIFT=1, default params -> 76800 W_EN; out(1,0) reads 0, out(2,2) W_ADDR 642 reads R_ADDR 161; DONE once.
REQ-034 MODE=1, SHIFT=2 (macro defined) -> 1200 W_EN; out(1,1) W_ADDR 41 reads R_ADDR 644.
REQ-035 SHIFT_FACTOR=3, MODE=0 -> treated as s=2: 307200 writes, max W_ADDR 307199.
REQ-036 START pulsed again mid-frame -> no restart, write count unchanged, single DONE.
REQ-037 RST_N low at write 500 -> next cycle R_EN=W_EN=BUSY=0, no DONE; fresh START runs a full frame correctly.
REQ-038 Macro undefined, MODE=1, SHIFT=1 -> zoom-in behaviour, 76800 writes.
